mux_sel_sched: RTL and testbench
================================

Name: mux_sel_sched

Overview:
- Round-robin select sequencer that drives the S0/S1 select pins of the tri-state-buffer 4:1 mux stage.
- Samples four channel requests and grants one channel at a time for a programmable dwell.
- Encodes the granted channel onto S0/S1 so the mux output z carries the selected input (A, B, C or D).
- Flags valid windows so the downstream consumer samples z only when the select is stable.

Parameters:
- DWELL, 4, cycles a channel is held once granted; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the dwell counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  channel requests; bit0=A, bit1=B, bit2=C, bit3=D.
- S0  output  1  mux select, inner level (A/B vs C/D).
- S1  output  1  mux select, outer level (f vs h path).
- sel_valid  output  1  high while S0/S1 are stable and z is sampleable.
- grant  output  4  one-hot granted channel; all zeros when sel_valid=0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): S0=0, S1=0, sel_valid=0, grant=0000, busy=0, state=IDLE, last=3, cnt=0. Round-robin search therefore starts at channel 0.
- Channel to select mapping, fixed by the mux wiring: S0=ch[1], S1=ch[0].
  - ch0 (A) gives S1S0=00.
  - ch1 (B) gives S1S0=10.
  - ch2 (C) gives S1S0=01.
  - ch3 (D) gives S1S0=11.
- All outputs are registered.
- Arbitration: next = first set bit of req scanning last+1, last+2, … mod 4, with last itself checked last.
- States: IDLE, HOLD, GAP (GAP exists only with the optional feature).
- IDLE:
  - req=0000: stay; S0/S1 hold their previous value; sel_valid=0.
  - Any req bit set: next cycle enter HOLD with ch=next, grant=onehot(ch), sel_valid=1, cnt=DWELL-1, last=ch.
  - Latency from req edge sample to sel_valid is 1 cycle.
- HOLD:
  - cnt decrements by 1 each cycle while cnt>0.
  - Expiry condition: cnt==0, or req[ch]==0 (early release), whichever comes first.
  - At expiry with req=0000: go to IDLE; sel_valid=0; grant=0; S0/S1 hold.
  - At expiry with next==ch (only the current channel requesting): re-grant the same channel, reload cnt=DWELL-1, sel_valid stays 1, no gap.
  - At expiry with next!=ch: switch to the new channel; handling of the switch depends on the optional feature.
- DWELL=1: each grant lasts exactly 1 cycle; a continuous 4-bit request rotates 0,1,2,3,0,… every cycle (no feature) or every 2 cycles (with GAP).
- Simultaneous events: requests arriving mid-dwell never preempt the current grant. The request vector is re-evaluated only at the expiry cycle.
- Reset mid-operation: all outputs return to reset values asynchronously; arbitration restarts from channel 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: MUX_SEL_BBM_EN (break-before-make).
- Defined:
  - A channel switch inserts exactly one GAP cycle.
  - During GAP: sel_valid=0, grant=0000, S0/S1 already driving the new channel code, so the tri-state nets settle before the window opens.
  - The next cycle enters HOLD with sel_valid=1. The next channel is latched at GAP entry.
  - Re-grants of the same channel and transitions from IDLE take no gap.
- Undefined: a switch goes HOLD to HOLD directly; sel_valid stays 1 and S0/S1 change in the same edge as grant.

Test Plan:
- Reset, then req=0000 for 5 cycles: S1S0=00, sel_valid=0, grant=0000, busy=0 throughout.
- DWELL=4, req=0100 held: 1 cycle after sample, grant=0100, S1S0=01, sel_valid=1. Grant stays 0100 with no gap (same-channel re-grant every 4 cycles).
- DWELL=4, req=1111 held, no macro: grants 0001, 0010, 0100, 1000, 0001 each for 4 cycles. S1S0 sequence is 00, 10, 01, 11.
- Same stimulus with MUX_SEL_BBM_EN: a 1-cycle sel_valid=0 / grant=0000 gap between each grant. S1S0 changes on the gap cycle; the period per channel is 5 cycles.
- Grant ch1 (req=0010), drop req[1] after 2 cycles while req[3]=1: switch to ch3 (S1S0=11) at the next edge without waiting for dwell. Then drop all req: IDLE, sel_valid=0, S1S0 stays 11.
- Assert rst mid-HOLD on ch2: outputs go to S1S0=00, sel_valid=0, grant=0 immediately (before the next clk edge). After release with req=1111, the first grant is ch0.

Source files
------------

// File: rtl/mux_sel_sched.sv
// mux_sel_sched: round-robin select sequencer for the tri-state 4:1 mux stage.
// It grants one requesting channel at a time for DWELL cycles and drives the
// S0/S1 mux selects with the code for that channel. sel_valid marks the cycles
// where z may be sampled. Every output is registered.
// Optional feature: defining MUX_SEL_BBM_EN enables break-before-make. With it,
// a channel switch inserts one GAP cycle. During GAP the selects already carry
// the new code, but sel_valid and grant stay low.
module mux_sel_sched #(
    parameter int DWELL = 4,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic       S0,
    output logic       S1,
    output logic       sel_valid,
    output logic [3:0] grant,
    output logic       busy
);

`ifdef MUX_SEL_BBM_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1} state_t;
`endif

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic             sel_valid_q, sel_valid_d;
    logic [3:0]       grant_q, grant_d;
    logic             busy_q, busy_d;

    logic [1:0]       nxt;
    logic             expire;

    // Pick the first requester after 'base'. The scan wraps, so 'base'
    // itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Next-state logic. The request vector is only looked at in IDLE and at
    // the expiry cycle of a HOLD, so a new request never preempts a grant.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        sel_valid_d = sel_valid_q;
        grant_d     = grant_q;
        nxt         = rr_pick(req, last_q);
        expire      = (cnt_q == '0) || !req[ch_q];

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_HOLD;
                    ch_d        = nxt;
                    last_d      = nxt;
                    cnt_d       = RELOAD;
                    sel_valid_d = 1'b1;
                    grant_d     = 4'b0001 << nxt;
                    s0_d        = nxt[1];
                    s1_d        = nxt[0];
                end
            end
            ST_HOLD: begin
                if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (req == 4'b0000) begin
                    // Selects keep their last code in IDLE.
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
                    grant_d     = 4'b0000;
                end else if (nxt == ch_q) begin
                    // Only the current channel is still asking: re-grant it
                    // seamlessly.
                    cnt_d = RELOAD;
                end else begin
`ifdef MUX_SEL_BBM_EN
                    // Close the window now, but drive the new code so the
                    // tri-state nets settle before the window reopens.
                    state_d     = ST_GAP;
                    ch_d        = nxt;
                    last_d      = nxt;
                    sel_valid_d = 1'b0;
                    grant_d     = 4'b0000;
                    s0_d        = nxt[1];
                    s1_d        = nxt[0];
`else
                    ch_d        = nxt;
                    last_d      = nxt;
                    cnt_d       = RELOAD;
                    grant_d     = 4'b0001 << nxt;
                    s0_d        = nxt[1];
                    s1_d        = nxt[0];
`endif
                end
            end
`ifdef MUX_SEL_BBM_EN
            ST_GAP: begin
                state_d     = ST_HOLD;
                cnt_d       = RELOAD;
                sel_valid_d = 1'b1;
                grant_d     = 4'b0001 << ch_q;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. Reset is asynchronous, and after reset
    // arbitration starts at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= 2'd0;
            last_q      <= 2'd3;
            cnt_q       <= '0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            sel_valid_q <= 1'b0;
            grant_q     <= 4'b0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            sel_valid_q <= sel_valid_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign S0        = s0_q;
    assign S1        = s1_q;
    assign sel_valid = sel_valid_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux_sel_sched.sv
// Directed testbench for mux_sel_sched. The results are packed as
// {busy, sel_valid, S1, S0, grant}. dut0 uses DWELL=4 and dut1 uses DWELL=1.
module tb_mux_sel_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req0 = 4'b0000;
    logic [3:0] req1 = 4'b0000;

    logic       s0_0, s1_0, valid_0, busy_0;
    logic [3:0] grant_0;
    logic       s0_1, s1_1, valid_1, busy_1;
    logic [3:0] grant_1;

    logic [7:0] obs0, obs1;
    assign obs0 = {busy_0, valid_0, s1_0, s0_0, grant_0};
    assign obs1 = {busy_1, valid_1, s1_1, s0_1, grant_1};

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected packed outputs: HOLD on channel n, and GAP heading to channel n.
    logic [7:0] ch_pack  [4] = '{8'b1100_0001, 8'b1110_0010, 8'b1101_0100, 8'b1111_1000};
    logic [7:0] gap_pack [4] = '{8'b1000_0000, 8'b1010_0000, 8'b1001_0000, 8'b1011_0000};

    mux_sel_sched #(.DWELL(4), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .req(req0),
        .S0(s0_0), .S1(s1_0), .sel_valid(valid_0), .grant(grant_0), .busy(busy_0)
    );

    mux_sel_sched #(.DWELL(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req(req1),
        .S0(s0_1), .S1(s1_1), .sel_valid(valid_1), .grant(grant_1), .busy(busy_1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end else begin
            $display("ok   %s: %b", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e;

        // Reset state
        #2;
        check_val("async_reset", obs0, 8'b0000_0000);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("idle_%0d", k), obs0, 8'b0000_0000);
        end

        // Single channel C held: seamless re-grant
        req0 = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_val($sformatf("hold_c_%0d", k), obs0, 8'b1101_0100);
        end
        req0 = 4'b0000;
        tick();
        check_val("c_release_idle", obs0, 8'b0001_0000);

        // Re-reset so the rotation starts at channel 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef MUX_SEL_BBM_EN
            if (k < 5)           e = ch_pack[0];
            else if (k % 5 == 0) e = gap_pack[(k / 5) % 4];
            else                 e = ch_pack[(k / 5) % 4];
`else
            e = ch_pack[((k - 1) / 4) % 4];
`endif
            check_val($sformatf("rot_%0d", k), obs0, e);
        end
        req0 = 4'b0000;
        tick();
        tick();

        // Early release of B while D is requesting
        req0 = 4'b0010;
        tick();
        check_val("b_grant_1", obs0, ch_pack[1]);
        tick();
        check_val("b_grant_2", obs0, ch_pack[1]);
        req0 = 4'b1000;
        tick();
`ifdef MUX_SEL_BBM_EN
        check_val("early_gap", obs0, gap_pack[3]);
        tick();
`endif
        check_val("early_switch_d", obs0, ch_pack[3]);
        req0 = 4'b0000;
        tick();
        check_val("d_release_idle", obs0, 8'b0011_0000);

        // Reset while holding channel C
        req0 = 4'b0100;
        tick();
        tick();
        check_val("pre_rst_c", obs0, ch_pack[2]);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_async", obs0, 8'b0000_0000);
        tick();
        req0 = 4'b1111;
        rst  = 1'b0;
        tick();
        check_val("post_rst_ch0", obs0, ch_pack[0]);

        // DWELL=1 rotation on dut1
        req1 = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
`ifdef MUX_SEL_BBM_EN
            if (k % 2 == 1) e = ch_pack[((k - 1) / 2) % 4];
            else            e = gap_pack[(k / 2) % 4];
`else
            e = ch_pack[(k - 1) % 4];
`endif
            check_val($sformatf("dw1_%0d", k), obs1, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
